// File: rtl/pilot_mode_ctrl.sv
// Autopilot mode controller: debounces the helm panel buttons, runs the STBY/CAP
// mode machine, holds the heading setpoint and drives the actuator and LED outputs.
module pilot_mode_ctrl #(
    parameter logic [15:0] DEBOUNCE_CYC = 16'd50000,
    parameter logic [23:0] LONG_CYC     = 24'd2500000,
    parameter logic [23:0] BLINK_CYC    = 24'd12500000,
    parameter logic [8:0]  DEADBAND     = 9'd3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bp_stby_i,
    input  logic       bp_babord_i,
    input  logic       bp_tribord_i,
    input  logic [8:0] cap_mesure_i,
    output logic       mode_o,
    output logic [8:0] consigne_o,
    output logic       verin_babord_o,
    output logic       verin_tribord_o,
    output logic       ledstby_o,
    output logic       ledbabord_o,
    output logic       ledtribord_o
);

    typedef enum logic {ST_STBY = 1'b0, ST_CAP = 1'b1} state_t;

    // Arming needs more stable-released samples than the synchroniser holds after reset,
    // so a button held through reset can never arm from the reset values alone.
    localparam logic [16:0] ARM_CYC = {1'b0, DEBOUNCE_CYC} + 17'd2;

    // Button index: 0 = stby, 1 = babord, 2 = tribord
    logic [2:0]       w_raw;
    logic [2:0]       r_sync1, r_sync2, r_db, r_arm;
    logic [2:0][15:0] r_db_cnt;
    logic [2:0][16:0] r_arm_cnt;
    logic [2:0]       w_pressed;

    assign w_raw     = {bp_tribord_i, bp_babord_i, bp_stby_i};
    assign w_pressed = r_arm & ~r_db;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= '1;
            r_sync2   <= '1;
            r_db      <= '1;
            r_arm     <= '0;
            r_db_cnt  <= '0;
            r_arm_cnt <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DEBOUNCE_CYC - 16'd1) begin
                    r_db[i]     <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 16'd1;
                end

                if (!r_sync2[i]) begin
                    r_arm_cnt[i] <= '0;
                end else if (!r_arm[i]) begin
                    if (r_arm_cnt[i] == ARM_CYC - 17'd1) r_arm[i] <= 1'b1;
                    else r_arm_cnt[i] <= r_arm_cnt[i] + 17'd1;
                end
            end
        end
    end

    // Press classification for babord (0) and tribord (1)
    logic [1:0][23:0] r_press_cnt;
    logic [1:0]       w_short, w_long, w_ev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_press_cnt <= '0;
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (!w_pressed[j+1]) r_press_cnt[j] <= '0;
                else if (r_press_cnt[j] != LONG_CYC) r_press_cnt[j] <= r_press_cnt[j] + 24'd1;
            end
        end
    end

    always_comb begin
        w_short = '0;
        w_long  = '0;
        for (int j = 0; j < 2; j++) begin
            w_short[j] = !w_pressed[j+1] && (r_press_cnt[j] != '0) && (r_press_cnt[j] < LONG_CYC);
            w_long[j]  = w_pressed[j+1] && (r_press_cnt[j] == LONG_CYC - 24'd1);
        end
    end
    assign w_ev = w_short | w_long;

    logic r_stby_prev;
    logic w_ev_stby;
    assign w_ev_stby = w_pressed[0] & ~r_stby_prev;

    // Setpoint arithmetic, mod 360
    logic       w_cap_ok;
    logic [8:0] w_step_bab, w_step_tri, w_dec;
    logic [9:0] w_sum;
    logic [9:0] w_inc;

    assign w_cap_ok   = (cap_mesure_i <= 9'd359);
    assign w_step_bab = w_long[0] ? 9'd10 : 9'd1;
    assign w_step_tri = w_long[1] ? 9'd10 : 9'd1;
    assign w_dec      = (consigne_o >= w_step_bab) ? (consigne_o - w_step_bab)
                                                   : (consigne_o + 9'd360 - w_step_bab);
    assign w_sum      = {1'b0, consigne_o} + {1'b0, w_step_tri};
    assign w_inc      = (w_sum >= 10'd360) ? (w_sum - 10'd360) : w_sum;

    // Mode FSM
    state_t     r_state, w_state_nxt;
    logic [8:0] r_consigne, w_consigne_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_STBY;
            r_consigne  <= '0;
            r_stby_prev <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_consigne  <= w_consigne_nxt;
            r_stby_prev <= w_pressed[0];
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_consigne_nxt = r_consigne;
        case (r_state)
            ST_STBY: begin
                if (w_ev_stby && w_cap_ok) begin
                    w_state_nxt    = ST_CAP;
                    w_consigne_nxt = cap_mesure_i;
                end
            end
            ST_CAP: begin
                if (w_ev_stby) w_state_nxt = ST_STBY;
                else if (w_ev[0] && !w_ev[1]) w_consigne_nxt = w_dec;
                else if (w_ev[1] && !w_ev[0]) w_consigne_nxt = w_inc[8:0];
            end
            default: w_state_nxt = ST_STBY;
        endcase
    end

    assign mode_o     = (r_state == ST_CAP);
    assign consigne_o = r_consigne;

    // Heading error folded into -179..+180
    logic signed [9:0] w_diff, w_err, w_db_s;
    logic              w_auto_bab, w_auto_tri;

    assign w_diff = $signed({1'b0, r_consigne}) - $signed({1'b0, cap_mesure_i});
    assign w_db_s = $signed({1'b0, DEADBAND});

    always_comb begin
        w_err = w_diff;
        if (w_diff > 10'sd180) w_err = w_diff - 10'sd360;
        else if (w_diff <= -10'sd180) w_err = w_diff + 10'sd360;
    end

    assign w_auto_tri = w_cap_ok && (w_err > w_db_s);
    assign w_auto_bab = w_cap_ok && (w_err < -w_db_s);

    logic        r_verin_bab, r_verin_tri, r_led_bab, r_led_tri, r_led_stby;
    logic [23:0] r_blink_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_verin_bab <= 1'b0;
            r_verin_tri <= 1'b0;
            r_led_bab   <= 1'b0;
            r_led_tri   <= 1'b0;
            r_led_stby  <= 1'b1;
            r_blink_cnt <= '0;
        end else begin
            if (r_state == ST_CAP) begin
                r_verin_bab <= w_auto_bab;
                r_verin_tri <= w_auto_tri;
            end else begin
                r_verin_bab <= w_pressed[1] & ~w_pressed[2];
                r_verin_tri <= w_pressed[2] & ~w_pressed[1];
            end
            r_led_bab <= w_pressed[1];
            r_led_tri <= w_pressed[2];
            // Blink restarts lit on every CAP entry and is steady-on in STBY
            if (w_state_nxt == ST_STBY || r_state == ST_STBY) begin
                r_blink_cnt <= '0;
                r_led_stby  <= 1'b1;
            end else if (r_blink_cnt == BLINK_CYC - 24'd1) begin
                r_blink_cnt <= '0;
                r_led_stby  <= ~r_led_stby;
            end else begin
                r_blink_cnt <= r_blink_cnt + 24'd1;
            end
        end
    end

    assign verin_babord_o  = r_verin_bab;
    assign verin_tribord_o = r_verin_tri;
    assign ledbabord_o     = r_led_bab;
    assign ledtribord_o    = r_led_tri;
    assign ledstby_o       = r_led_stby;

endmodule

// File: tb/tb_pilot_mode_ctrl.sv
// Directed bench for pilot_mode_ctrl with short debounce/long/blink timings.
module tb_pilot_mode_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       bp_stby, bp_bab, bp_tri;
    logic [8:0] cap;
    logic       mode, v_bab, v_tri, l_stby, l_bab, l_tri;
    logic [8:0] consigne;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pilot_mode_ctrl #(
        .DEBOUNCE_CYC(16'd4),
        .LONG_CYC    (24'd20),
        .BLINK_CYC   (24'd8),
        .DEADBAND    (9'd3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bp_stby_i      (bp_stby),
        .bp_babord_i    (bp_bab),
        .bp_tribord_i   (bp_tri),
        .cap_mesure_i   (cap),
        .mode_o         (mode),
        .consigne_o     (consigne),
        .verin_babord_o (v_bab),
        .verin_tribord_o(v_tri),
        .ledstby_o      (l_stby),
        .ledbabord_o    (l_bab),
        .ledtribord_o   (l_tri)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_verin(input string tag, input logic eb, input logic et);
        chk({tag, "_bab"}, 32'(v_bab), 32'(eb));
        chk({tag, "_tri"}, 32'(v_tri), 32'(et));
    endtask

    // Debounced stby press (held 7 cycles so the mode update is visible), then release
    task automatic stby_press();
        bp_stby = 1'b0;
        tick(7);
        bp_stby = 1'b1;
        tick(10);
    endtask

    initial begin
        reset = 1'b1; bp_stby = 1'b1; bp_bab = 1'b1; bp_tri = 1'b1; cap = 9'd120;
        tick(3);
        chk("rst_mode", 32'(mode), 0);
        chk("rst_consigne", 32'(consigne), 0);
        chk("rst_ledstby", 32'(l_stby), 1);
        chk("rst_ledbab", 32'(l_bab), 0);
        chk("rst_ledtri", 32'(l_tri), 0);
        chk_verin("rst", 1'b0, 1'b0);
        reset = 1'b0;
        tick(10);

        // STBY -> CAP with heading 120, blink, then back to STBY
        bp_stby = 1'b0;
        tick(6);
        chk("cap_entry_early", 32'(mode), 0);
        tick(1);
        chk("cap_entry_mode", 32'(mode), 1);
        chk("cap_entry_consigne", 32'(consigne), 120);
        chk("blink_start", 32'(l_stby), 1);
        bp_stby = 1'b1;
        tick(7);
        chk("blink_e7", 32'(l_stby), 1);
        tick(1);
        chk("blink_e8", 32'(l_stby), 0);
        tick(8);
        chk("blink_e16", 32'(l_stby), 1);
        bp_stby = 1'b0;
        tick(7);
        chk("cap_exit_mode", 32'(mode), 0);
        chk("cap_exit_ledstby", 32'(l_stby), 1);
        chk("cap_exit_consigne", 32'(consigne), 120);
        bp_stby = 1'b1;
        tick(10);

        // Setpoint wrap: short babord from 0, long tribord from 359
        cap = 9'd0;
        stby_press();
        chk("cap0_mode", 32'(mode), 1);
        chk("cap0_consigne", 32'(consigne), 0);
        bp_bab = 1'b0;
        tick(10);
        bp_bab = 1'b1;
        tick(6);
        chk("bab_short_early", 32'(consigne), 0);
        tick(1);
        chk("bab_short_wrap", 32'(consigne), 359);
        tick(5);
        bp_tri = 1'b0;
        tick(25);
        chk("tri_long_early", 32'(consigne), 359);
        tick(1);
        chk("tri_long_wrap", 32'(consigne), 9);
        tick(4);
        bp_tri = 1'b1;
        tick(10);
        chk("tri_long_release", 32'(consigne), 9);

        // Actuator error path with setpoint 10
        bp_tri = 1'b0;
        tick(8);
        bp_tri = 1'b1;
        tick(10);
        chk("tri_short", 32'(consigne), 10);
        cap = 9'd350; tick(1); chk_verin("err_p20", 1'b0, 1'b1);
        cap = 9'd12;  tick(1); chk_verin("err_m2", 1'b0, 1'b0);
        cap = 9'd20;  tick(1); chk_verin("err_m10", 1'b1, 1'b0);
        cap = 9'd400; tick(1); chk_verin("cap_invalid", 1'b0, 1'b0);
        cap = 9'd7;   tick(1); chk_verin("err_p3", 1'b0, 1'b0);
        cap = 9'd6;   tick(1); chk_verin("err_p4", 1'b0, 1'b1);
        cap = 9'd13;  tick(1); chk_verin("err_m3", 1'b0, 1'b0);
        cap = 9'd190; tick(1); chk_verin("err_p180", 1'b0, 1'b1);
        cap = 9'd189; tick(1); chk_verin("err_m179", 1'b1, 1'b0);

        // Manual steering in STBY
        cap = 9'd10;
        stby_press();
        chk("manual_mode", 32'(mode), 0);
        bp_bab = 1'b0;
        tick(6);
        chk("manual_bab_early", 32'(v_bab), 0);
        chk("manual_ledbab_early", 32'(l_bab), 0);
        tick(1);
        chk_verin("manual_bab", 1'b1, 1'b0);
        chk("manual_ledbab", 32'(l_bab), 1);
        bp_tri = 1'b0;
        tick(7);
        chk_verin("manual_both", 1'b0, 1'b0);
        chk("manual_ledtri", 32'(l_tri), 1);
        bp_tri = 1'b1;
        tick(10);
        chk_verin("manual_tri_rel", 1'b1, 1'b0);
        bp_tri = 1'b0;
        tick(3);
        bp_tri = 1'b1;
        tick(5);
        chk("glitch_ledtri_a", 32'(l_tri), 0);
        chk_verin("glitch_a", 1'b1, 1'b0);
        tick(5);
        chk("glitch_ledtri_b", 32'(l_tri), 0);
        chk_verin("glitch_b", 1'b1, 1'b0);
        bp_bab = 1'b1;
        tick(10);

        // Simultaneous events in CAP
        cap = 9'd100;
        stby_press();
        chk("sim_cap_consigne", 32'(consigne), 100);
        bp_tri = 1'b0;
        tick(5);
        bp_tri = 1'b1;
        bp_stby = 1'b0;
        tick(6);
        chk("sim_stby_early", 32'(mode), 1);
        tick(1);
        chk("sim_stby_mode", 32'(mode), 0);
        chk("sim_stby_consigne", 32'(consigne), 100);
        bp_stby = 1'b1;
        tick(10);
        stby_press();
        chk("sim_recap_mode", 32'(mode), 1);
        bp_bab = 1'b0; bp_tri = 1'b0;
        tick(8);
        bp_bab = 1'b1; bp_tri = 1'b1;
        tick(10);
        chk("sim_cancel", 32'(consigne), 100);
        bp_tri = 1'b0;
        tick(8);
        bp_tri = 1'b1;
        tick(10);
        chk("single_tri", 32'(consigne), 101);

        // Reset while babord is held in CAP
        bp_bab = 1'b0;
        tick(10);
        reset = 1'b1;
        tick(2);
        chk("midrst_mode", 32'(mode), 0);
        chk("midrst_consigne", 32'(consigne), 0);
        chk_verin("midrst", 1'b0, 1'b0);
        reset = 1'b0;
        tick(40);
        chk_verin("held_after_rst", 1'b0, 1'b0);
        chk("held_ledbab", 32'(l_bab), 0);
        chk("held_mode", 32'(mode), 0);
        bp_bab = 1'b1;
        tick(12);
        bp_bab = 1'b0;
        tick(6);
        chk("repress_early", 32'(v_bab), 0);
        tick(1);
        chk_verin("repress", 1'b1, 1'b0);
        chk("repress_ledbab", 32'(l_bab), 1);
        bp_bab = 1'b1;
        tick(10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pilot_mode_ctrl.md
# pilot_mode_ctrl

Autopilot mode controller for the sailboat helm. It debounces the three front-panel push-buttons (standby, port/babord, starboard/tribord) and runs the STBY/CAP mode state machine. It maintains the heading setpoint in degrees and drives the port/starboard actuator commands and panel LEDs. It sits between the raw panel pins and the helm actuator, and takes the measured heading from the compass peripheral.

## Interface
Parameters:
- DEBOUNCE_CYC, 16'd50000, number of cycles a synchronised button level must be stable to be accepted
- LONG_CYC, 24'd2500000, press duration (cycles, after debounce) that makes a press "long"
- BLINK_CYC, 24'd12500000, half-period of the standby LED blink in CAP mode
- DEADBAND, 9'd3, heading-error deadband in degrees

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- bp_stby_i  in  1  standby button, raw, active-low (idle 1)
- bp_babord_i  in  1  port button, raw, active-low
- bp_tribord_i  in  1  starboard button, raw, active-low
- cap_mesure_i  in  9  measured heading 0..359; values >359 are invalid
- mode_o  out  1  0 = STBY, 1 = CAP
- consigne_o  out  9  heading setpoint 0..359
- verin_babord_o  out  1  actuator command, steer to port
- verin_tribord_o  out  1  actuator command, steer to starboard
- ledstby_o  out  1  standby LED, active-high
- ledbabord_o  out  1  port LED, active-high
- ledtribord_o  out  1  starboard LED, active-high

## Operation
- Input conditioning: each button passes through a 2-FF synchroniser, then a per-button stability counter. The debounced level changes only after DEBOUNCE_CYC consecutive equal samples. "Pressed" = debounced level 0.
- Press classification, per babord/tribord button:
  - A counter runs while the button is pressed and saturates at LONG_CYC.
  - Short press: released with the counter < LONG_CYC; one event on the release cycle.
  - Long press: one event on the cycle the counter reaches LONG_CYC; nothing further until release.
- STBY events: event on the debounced falling edge of the stby button.
- Mode FSM, two states, STBY (reset) and CAP:
  - STBY + stby event, with cap_mesure_i ≤ 359 → CAP, and consigne_o ← cap_mesure_i.
  - STBY + stby event, with cap_mesure_i invalid → stay in STBY.
  - CAP + stby event → STBY; consigne_o keeps its value.
- Setpoint, in CAP only, mod 360:
  - babord short → −1, babord long → −10.
  - tribord short → +1, tribord long → +10.
  - Wrap examples: 0−1 = 359, 5−10 = 355, 359+1 = 0, 355+10 = 5.
- Simultaneous events:
  - A stby event wins; any babord/tribord event in the same cycle is discarded.
  - Babord and tribord events in the same cycle cancel; setpoint unchanged.
- Actuator outputs, STBY (manual):
  - verin_babord_o = babord pressed AND NOT tribord pressed.
  - verin_tribord_o = symmetric.
- Actuator outputs, CAP:
  - err = consigne − mesure, folded into −179..+180 (diff > 180 → −360; diff ≤ −180 → +360); 10-bit signed arithmetic.
  - verin_tribord_o = err > DEADBAND; verin_babord_o = err < −DEADBAND.
  - Both outputs are 0 when cap_mesure_i is invalid.
  - The two verin outputs are never both 1.
- LEDs:
  - ledbabord_o / ledtribord_o = debounced pressed state of the respective button, in both modes.
  - ledstby_o = 1 steady in STBY.
  - In CAP, ledstby_o toggles every BLINK_CYC cycles; the blink counter restarts and the LED starts at 1 on CAP entry.

## Timing
- Reset values:
  - mode_o = 0, consigne_o = 0, ledstby_o = 1; all other outputs 0.
  - Debounced levels = 1 (released); all counters = 0.
  - Reset mid-press returns to STBY. The held button must be released and re-debounced before it generates an event.
- Latency:
  - Raw edge → debounced level change: 2 + DEBOUNCE_CYC cycles.
  - Debounced event → mode_o/consigne_o update: 1 cycle (registered).
  - All outputs are registered. verin_* and LEDs follow their sources with 1 cycle of latency.
- Error/actuator path: err computed combinationally from registered consigne_o and cap_mesure_i, then registered; 1 cycle of latency from a cap_mesure_i change.
- Glitches shorter than DEBOUNCE_CYC cycles produce no level change and no event.

## Test plan
Benches use DEBOUNCE_CYC = 4, LONG_CYC = 20, BLINK_CYC = 8, DEADBAND = 3.
- Reset, then stby press with cap_mesure_i = 120 → mode_o = 1 and consigne_o = 120. ledstby_o toggles every 8 cycles, starting at 1. Second stby press → mode_o = 0, ledstby_o = 1, consigne_o stays 120.
- CAP, consigne 0: babord short press (10 cycles) → consigne_o = 359. Then tribord held 30 cycles → exactly one +10 event → consigne_o = 9, no further change on release.
- CAP, consigne 10: cap_mesure_i = 350 → err = +20 → verin_tribord_o = 1. cap_mesure_i = 12 → err = −2 → both 0. cap_mesure_i = 20 → verin_babord_o = 1. cap_mesure_i = 400 → both 0.
- STBY: babord held → verin_babord_o = 1 and ledbabord_o = 1 after 2+4+1 cycles. Tribord also pressed → both verin outputs 0. A 3-cycle glitch on bp_tribord_i → no output change.
- CAP: stby and tribord events in the same cycle → mode_o = 0, consigne_o unchanged. Babord and tribord events in the same cycle → consigne_o unchanged.
- Reset asserted while babord is held in CAP → mode_o = 0, consigne_o = 0, all verin outputs 0. No event until the button is released and pressed again.
